hamming_decode_pipe: RTL and testbench



---
 rtl/hamming_pkg.sv | 33 +++
 rtl/hamming_correct.sv | 33 +++
 rtl/hamming_decode_pipe.sv | 109 ++++++++++
 tb/tb_hamming_decode_pipe.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hamming_pkg.sv
// ============================================================================
//  Module   : hamming_pkg
//  Purpose  : Shared Hamming(7,4) widths, bit positions and syndrome helper.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package hamming_pkg;

   localparam int CODE_W = 7;
   localparam int DATA_W = 4;
   localparam int SYN_W  = 3;

   // Codeword bit positions, matching the encoder output order
   localparam int BIT_P0 = 0;
   localparam int BIT_P1 = 1;
   localparam int BIT_D0 = 2;
   localparam int BIT_P2 = 3;
   localparam int BIT_D1 = 4;
   localparam int BIT_D2 = 5;
   localparam int BIT_D3 = 6;

   function automatic logic [SYN_W-1:0] calc_syndrome(input logic [CODE_W-1:0] c);
      logic [SYN_W-1:0] s;
      s[0] = c[BIT_P0] ^ c[BIT_D0] ^ c[BIT_D1] ^ c[BIT_D3];
      s[1] = c[BIT_P1] ^ c[BIT_D0] ^ c[BIT_D2] ^ c[BIT_D3];
      s[2] = c[BIT_P2] ^ c[BIT_D1] ^ c[BIT_D2] ^ c[BIT_D3];
      return s;
   endfunction

endpackage

`default_nettype wire

// File: rtl/hamming_correct.sv
// ============================================================================
//  Module   : hamming_correct
//  Purpose  : Combinational single-error correction and data extraction.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hamming_correct
   import hamming_pkg::*;
(
   input  logic [CODE_W-1:0] code,
   input  logic [SYN_W-1:0]  syndrome,
   output logic [DATA_W-1:0] data,
   output logic              corrected
);

   logic [CODE_W-1:0] w_flip;
   logic [CODE_W-1:0] w_fixed;

   // One-hot flip mask: syndrome k selects bit k-1, syndrome 0 selects nothing
   generate
      for (genvar i = 0; i < CODE_W; i++) begin : g_flip
         assign w_flip[i] = (syndrome == SYN_W'(i + 1));
      end
   endgenerate

   assign w_fixed   = code ^ w_flip;
   assign data      = {w_fixed[BIT_D3], w_fixed[BIT_D2], w_fixed[BIT_D1], w_fixed[BIT_D0]};
   assign corrected = |syndrome;

endmodule

`default_nettype wire

// File: rtl/hamming_decode_pipe.sv
// ============================================================================
//  Module   : hamming_decode_pipe
//  Purpose  : Two-stage valid/ready Hamming(7,4) SEC decoder with a
//             saturating corrected-word counter.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hamming_decode_pipe
   import hamming_pkg::*;
#(
   parameter int CNT_W = 16
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [6:0]        code_in,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [3:0]        data_out,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_corrected,
   output logic [2:0]        out_syndrome,
   input  logic              cnt_clr,
   output logic [CNT_W-1:0]  corr_count
);

   logic              r_s1_v;
   logic [CODE_W-1:0] r_s1_code;
   logic [SYN_W-1:0]  r_s1_syn;

   logic              r_s2_v;
   logic [DATA_W-1:0] r_s2_data;
   logic              r_s2_corr;
   logic [SYN_W-1:0]  r_s2_syn;

   logic [CNT_W-1:0]  r_cnt;

   logic              w_s2_adv;
   logic              w_s1_adv;
   logic              w_accept;
   logic              w_out_hs;
   logic [DATA_W-1:0] w_fix_data;
   logic              w_fix_corr;

   assign w_s2_adv = !r_s2_v || out_ready;
   assign w_s1_adv = !r_s1_v || w_s2_adv;
   assign w_accept = in_valid && w_s1_adv;
   assign w_out_hs = r_s2_v && out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_v    <= 1'b0;
         r_s1_code <= '0;
         r_s1_syn  <= '0;
      end else if (w_s1_adv) begin
         r_s1_v <= in_valid;
         if (w_accept) begin
            r_s1_code <= code_in;
            r_s1_syn  <= calc_syndrome(code_in);
         end
      end
   end

   hamming_correct u_correct (
      .code      (r_s1_code),
      .syndrome  (r_s1_syn),
      .data      (w_fix_data),
      .corrected (w_fix_corr)
   );

   // Payload only moves with a real word so idle outputs keep the last value
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s2_v    <= 1'b0;
         r_s2_data <= '0;
         r_s2_corr <= 1'b0;
         r_s2_syn  <= '0;
      end else if (w_s2_adv) begin
         r_s2_v <= r_s1_v;
         if (r_s1_v) begin
            r_s2_data <= w_fix_data;
            r_s2_corr <= w_fix_corr;
            r_s2_syn  <= r_s1_syn;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (cnt_clr) begin
         r_cnt <= '0;
      end else if (w_out_hs && r_s2_corr && !(&r_cnt)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign in_ready      = w_s1_adv;
   assign out_valid     = r_s2_v;
   assign data_out      = r_s2_data;
   assign out_corrected = r_s2_corr;
   assign out_syndrome  = r_s2_syn;
   assign corr_count    = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_hamming_decode_pipe.sv
// ============================================================================
//  Module   : tb_hamming_decode_pipe
//  Purpose  : Directed self-checking bench for hamming_decode_pipe.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hamming_decode_pipe;

   logic        clk;
   logic        rst_n;
   logic [6:0]  code_in;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  data_out;
   logic        out_valid;
   logic        out_ready;
   logic        out_corrected;
   logic [2:0]  out_syndrome;
   logic        cnt_clr;
   logic [15:0] corr_count;

   logic        in_ready4;
   logic [3:0]  data_out4;
   logic        out_valid4;
   logic        out_corrected4;
   logic [2:0]  out_syndrome4;
   logic [3:0]  corr_count4;

   int n_total = 0;
   int n_bad   = 0;
   int cyc     = 0;

   typedef struct {
      logic [3:0] d;
      logic [2:0] s;
      logic       c;
      int         pc;
      bit         lat;
   } exp_t;

   exp_t q[$];

   hamming_decode_pipe #(.CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .code_in(code_in), .in_valid(in_valid),
      .in_ready(in_ready), .data_out(data_out), .out_valid(out_valid),
      .out_ready(out_ready), .out_corrected(out_corrected),
      .out_syndrome(out_syndrome), .cnt_clr(cnt_clr), .corr_count(corr_count)
   );

   hamming_decode_pipe #(.CNT_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .code_in(code_in), .in_valid(in_valid),
      .in_ready(in_ready4), .data_out(data_out4), .out_valid(out_valid4),
      .out_ready(out_ready), .out_corrected(out_corrected4),
      .out_syndrome(out_syndrome4), .cnt_clr(cnt_clr), .corr_count(corr_count4)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [6:0] encode(input logic [3:0] d);
      logic p0, p1, p2;
      p0 = d[0] ^ d[1] ^ d[3];
      p1 = d[0] ^ d[2] ^ d[3];
      p2 = d[1] ^ d[2] ^ d[3];
      return {d[3], d[2], d[1], p2, d[0], p1, p0};
   endfunction

   // Present one word, wait for acceptance, queue its expected result
   task automatic send(input logic [6:0] code, input logic [3:0] d, input logic [2:0] s,
                       input bit lat);
      exp_t e;
      bit   acc;
      int   n;
      code_in  = code;
      in_valid = 1'b1;
      acc = 1'b0;
      n   = 0;
      e.pc = 0;
      while (!acc && n < 20) begin
         @(negedge clk);
         acc  = in_ready;
         e.pc = cyc;
         n++;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      if (!acc) begin
         check("send_timeout", in_ready, 1);
      end else begin
         e.d   = d;
         e.s   = s;
         e.c   = (s != 3'd0);
         e.lat = lat;
         q.push_back(e);
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() != 0 && n < 50) begin
         @(posedge clk);
         n++;
      end
      #1;
      check("drain_left", q.size(), 0);
   endtask

   task automatic pulse_clr();
      cnt_clr = 1'b1;
      @(posedge clk);
      #1;
      cnt_clr = 1'b0;
   endtask

   // Output monitor: scoreboard compare on handshakes, stability during stalls
   initial begin : monitor
      bit         prev;
      logic [7:0] pd;
      exp_t       e;
      prev = 1'b0;
      pd   = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev = 1'b0;
         end else begin
            if (prev) begin
               check("hold_valid", out_valid, 1);
               check("hold_data", {data_out, out_syndrome, out_corrected}, pd);
            end
            if (out_valid && out_ready) begin
               if (q.size() == 0) begin
                  check("stale_word", out_valid, 0);
               end else begin
                  e = q.pop_front();
                  check("data", data_out, e.d);
                  check("syndrome", out_syndrome, e.s);
                  check("corrected", out_corrected, e.c);
                  if (e.lat) check("latency", cyc, e.pc + 2);
               end
            end
            prev = out_valid && !out_ready;
            pd   = {data_out, out_syndrome, out_corrected};
         end
      end
   end

   initial begin
      logic [6:0] c;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      code_in   = '0;
      out_ready = 1'b1;
      cnt_clr   = 1'b0;

      #12;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_data", data_out, 0);
      check("rst_corrected", out_corrected, 0);
      check("rst_syndrome", out_syndrome, 0);
      check("rst_count", corr_count, 0);
      check("rst_count4", corr_count4, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Clean back-to-back stream
      send(7'h55, 4'hB, 3'd0, 1);
      send(7'h00, 4'h0, 3'd0, 1);
      send(7'h7F, 4'hF, 3'd0, 1);
      drain();
      check("clean_count", corr_count, 0);

      // Single-bit error on bit 4
      send(7'h45, 4'hB, 3'd5, 1);
      drain();
      check("err_count", corr_count, 1);
      check("err_count4", corr_count4, 1);

      // Exhaustive: every data value clean and with each single flip
      pulse_clr();
      for (int d = 0; d < 16; d++) begin
         for (int f = -1; f < 7; f++) begin
            c = encode(4'(d));
            if (f >= 0) c[f] = ~c[f];
            send(c, 4'(d), 3'(f + 1), 1);
         end
      end
      drain();
      check("exh_count", corr_count, 112);
      check("exh_count4_sat", corr_count4, 15);

      // Saturation: 20 corrected words
      pulse_clr();
      for (int i = 0; i < 20; i++) begin
         c = encode(4'(i % 16));
         c[i % 7] = ~c[i % 7];
         send(c, 4'(i % 16), 3'((i % 7) + 1), 1);
      end
      drain();
      check("sat_count", corr_count, 20);
      check("sat_count4", corr_count4, 4'hF);

      // Clear coinciding with a corrected handshake
      out_ready = 1'b0;
      c = encode(4'h3);
      c[2] = ~c[2];
      send(c, 4'h3, 3'd3, 0);
      for (int n = 0; n < 10 && !out_valid; n++) begin
         @(posedge clk);
         #1;
      end
      check("clr_wait_valid", out_valid, 1);
      out_ready = 1'b1;
      cnt_clr   = 1'b1;
      @(posedge clk);
      #1;
      cnt_clr = 1'b0;
      check("clr_wins", corr_count, 0);
      check("clr_wins4", corr_count4, 0);
      drain();

      // Backpressure during a 4-word burst
      out_ready = 1'b0;
      send(encode(4'h1), 4'h1, 3'd0, 0);
      c = encode(4'h2);
      c[6] = ~c[6];
      send(c, 4'h2, 3'd7, 0);
      @(negedge clk);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
      fork
         begin
            send(encode(4'hC), 4'hC, 3'd0, 0);
            c = encode(4'h9);
            c[0] = ~c[0];
            send(c, 4'h9, 3'd1, 0);
         end
         begin
            repeat (3) @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      drain();
      check("bp_count", corr_count, 2);

      // Reset with both stages full
      out_ready = 1'b0;
      c = encode(4'h5);
      c[3] = ~c[3];
      send(c, 4'h5, 3'd4, 0);
      send(encode(4'h6), 4'h6, 3'd0, 0);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_count", corr_count, 0);
      check("mid_rst_count4", corr_count4, 0);
      q.delete();
      @(posedge clk);
      #1;
      rst_n     = 1'b1;
      out_ready = 1'b1;
      check("post_rst_in_ready", in_ready, 1);
      repeat (6) @(posedge clk);
      #1;
      check("post_rst_out_valid", out_valid, 0);
      check("post_rst_count", corr_count, 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

endmodule

`default_nettype wire
